mem_boot_loader: RTL and testbench

//  Host-side loader that fills IMEM/DMEM from a byte stream and then releases the core, the

---
 rtl/boot_loader_pkg.sv | 12 +
 rtl/mem_boot_loader.sv | 136 +++++++++++++
 tb/tb_mem_boot_loader.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_loader_pkg.sv
// boot_loader_pkg: loader FSM states, frame command codes and memory depth helper
package boot_loader_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_CNT_LO, S_CNT_HI, S_DATA, S_WRITE, S_CSUM, S_RUN, S_ERROR
  } state_t;
  localparam logic [7:0] CMD_IMEM = 8'h01;
  localparam logic [7:0] CMD_DMEM = 8'h02;
  localparam logic [7:0] CMD_RUN  = 8'h03;
  function automatic logic [31:0] word_depth(input int bytes);
    return 32'(bytes / 4);
  endfunction
endpackage

// File: rtl/mem_boot_loader.sv
// mem_boot_loader: fills IMEM/DMEM from a byte stream, then releases the core (LOADER_CHECKSUM_EN adds a trailing XOR byte per frame)
module mem_boot_loader
  import boot_loader_pkg::*;
#(
  parameter int IMEM_SIZE_IN_BYTES = 1024,
  parameter int DMEM_SIZE_IN_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic        dmem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        core_reset,
  output logic        load_done,
  output logic        load_err
);
  localparam logic [31:0] IDEPTH = word_depth(IMEM_SIZE_IN_BYTES);
  localparam logic [31:0] DDEPTH = word_depth(DMEM_SIZE_IN_BYTES);
`ifdef LOADER_CHECKSUM_EN
  localparam bit     CSUM_EN = 1'b1;
  localparam state_t S_END   = S_CSUM;
  logic [7:0] csum_q, csum_d;
`else
  localparam bit     CSUM_EN = 1'b0;
  localparam state_t S_END   = S_IDLE;
`endif
  state_t      state_q, state_d;
  logic        dmem_q, dmem_d;
  logic [15:0] cnt_q, cnt_d, widx_q, widx_d, cnt_new;
  logic [1:0]  bidx_q, bidx_d;
  logic [31:0] word_q, word_d, depth;
  logic        err_q, err_d, done_q, done_d;
  logic        take, in_range, ovf, last, known;
  // state register and datapath flops; reset aborts any frame in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      dmem_q  <= 1'b0;
      cnt_q   <= '0;
      widx_q  <= '0;
      bidx_q  <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      dmem_q  <= dmem_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      bidx_q  <= bidx_d;
      word_q  <= word_d;
      err_q   <= err_d;
      done_q  <= done_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end
  // next state: frame parsing, little-endian word assembly and word counting
  always_comb begin
    take     = rx_valid && rx_ready;
    depth    = dmem_q ? DDEPTH : IDEPTH;
    in_range = {16'd0, widx_q} < depth;
    ovf      = {16'd0, cnt_q} > depth;
    last     = widx_q == cnt_q - 16'd1;
    cnt_new  = {rx_data, cnt_q[7:0]};
    known    = rx_data inside {CMD_IMEM, CMD_DMEM, CMD_RUN};
    state_d  = state_q;
    dmem_d   = dmem_q;
    cnt_d    = cnt_q;
    widx_d   = widx_q;
    bidx_d   = bidx_q;
    word_d   = word_q;
    err_d    = err_q;
    done_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d   = !take ? csum_q : state_q == S_IDLE ? rx_data : csum_q ^ rx_data;
`endif
    case (state_q)
      S_IDLE: if (take) begin
        dmem_d  = rx_data == CMD_DMEM;
        widx_d  = '0;
        bidx_d  = '0;
        state_d = !known ? S_ERROR : rx_data == CMD_RUN ? S_RUN : S_CNT_LO;
        done_d  = rx_data == CMD_RUN;
        err_d   = err_q || !known;
      end
      S_CNT_LO: if (take) begin
        cnt_d   = {8'd0, rx_data};
        state_d = S_CNT_HI;
      end
      S_CNT_HI: if (take) begin
        cnt_d   = cnt_new;
        state_d = cnt_new != '0 ? S_DATA : S_END;
        done_d  = cnt_new == '0 && !CSUM_EN;
      end
      S_DATA: if (take) begin
        word_d  = {rx_data, word_q[31:8]};
        bidx_d  = bidx_q + 2'd1;
        state_d = bidx_q == 2'd3 ? S_WRITE : S_DATA;
      end
      S_WRITE: begin
        widx_d  = widx_q + 16'd1;
        err_d   = err_q || !in_range;
        state_d = last ? S_END : S_DATA;
        done_d  = last && !CSUM_EN && !ovf;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: if (take) begin
        state_d = S_IDLE;
        done_d  = rx_data == csum_q && !ovf;
        err_d   = err_q || rx_data != csum_q;
      end
`endif
      default: ;
    endcase
  end
  // outputs: strobes only in WRITE and only for in-range word indices
  always_comb begin
    rx_ready   = reset && (state_q inside {S_IDLE, S_CNT_LO, S_CNT_HI, S_DATA, S_CSUM});
    imem_we    = state_q == S_WRITE && !dmem_q && in_range;
    dmem_we    = state_q == S_WRITE && dmem_q && in_range;
    mem_addr   = {14'd0, widx_q, 2'b00};
    mem_wdata  = word_q;
    core_reset = state_q != S_RUN;
    load_done  = done_q;
    load_err   = err_q;
  end
endmodule

// File: tb/tb_mem_boot_loader.sv
// tb_mem_boot_loader: randomized frame stimulus checked against a frame-level reference model
`timescale 1ns/1ps
module tb_mem_boot_loader;
  localparam int DEPTH = 256;
  typedef struct packed {logic d; logic [31:0] a; logic [31:0] w;} wr_t;
  logic clk = 0, reset = 0, rx_valid = 0;
  logic [7:0] rx_data = 0;
  logic rx_ready, imem_we, dmem_we, core_reset, load_done, load_err;
  logic [31:0] mem_addr, mem_wdata;
  int checks = 0, failures = 0, done_cnt = 0, max_gap = 0;
  bit exp_done, exp_err;
  wr_t obs[$], exp_q[$];
  logic [31:0] wd[$];
  logic [7:0] fb[$];

  mem_boot_loader dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .imem_we(imem_we), .dmem_we(dmem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_reset(core_reset),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) obs.push_back(wr_t'({1'b0, mem_addr, mem_wdata}));
    if (dmem_we) obs.push_back(wr_t'({1'b1, mem_addr, mem_wdata}));
    if (load_done) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  // reference model: frame bytes and the writes/flags the frame must produce
  task automatic make_frame(input logic [7:0] cmd, input bit bad);
    int n = wd.size();
    fb = {cmd, 8'(n), 8'(n >> 8)};
    foreach (wd[i]) for (int k = 0; k < 4; k++) fb.push_back(wd[i][8*k +: 8]);
`ifdef LOADER_CHECKSUM_EN
    begin
      logic [7:0] x = 0;
      foreach (fb[i]) x ^= fb[i];
      fb.push_back(bad ? ~x : x);
    end
`endif
    exp_q = {};
    foreach (wd[i]) if (i < DEPTH) exp_q.push_back(wr_t'({cmd == 8'h02, 32'(i * 4), wd[i]}));
    exp_done = !bad && n <= DEPTH;
    exp_err  = bad || n > DEPTH;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    bit acc = 0;
    @(negedge clk);
    rx_valid = 1;
    rx_data = b;
    while (!acc && t < 20) begin
      #1 acc = rx_ready;
      @(posedge clk);
      t++;
      if (!acc) @(negedge clk);
    end
    if (!acc) begin
      checks++; failures++;
      $display("FAIL accept byte=%h got=not_accepted exp=accepted", b);
    end
  endtask

  task automatic send_frame();
    obs = {};
    done_cnt = 0;
    foreach (fb[i]) begin
      repeat ($urandom_range(max_gap)) begin
        @(negedge clk);
        rx_valid = 0;
        rx_data = 8'($urandom);
      end
      send_byte(fb[i]);
    end
    @(negedge clk);
    rx_valid = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 0;
    rx_valid = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1 checks++;
    if ({rx_ready, imem_we, dmem_we, mem_addr, mem_wdata, core_reset, load_done, load_err} !== {3'b000, 64'd0, 3'b100}) begin
      failures++;
      $display("FAIL reset_vals got=%b/%h/%h/%b exp=000/0/0/100", {rx_ready, imem_we, dmem_we}, mem_addr, mem_wdata, {core_reset, load_done, load_err});
    end
    reset = 1;
    @(negedge clk);
    #1 checks++;
    if (rx_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", rx_ready); end
  endtask

  task automatic test_imem_fixed();
    wd = {32'h00000013, 32'h00100073};
    make_frame(8'h01, 0);
    send_frame();
    checks++;
    if (obs.size() != exp_q.size()) begin failures++; $display("FAIL imem_count got=%0d exp=%0d", obs.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs.size()) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin failures++; $display("FAIL imem_wr%0d got=%h exp=%h", i, obs[i], exp_q[i]); end
    end
    checks++;
    if ({done_cnt, core_reset, load_err} !== {32'd1, 2'b10}) begin
      failures++;
      $display("FAIL imem_flags got=done%0d/%b%b exp=done1/10", done_cnt, core_reset, load_err);
    end
  endtask

  task automatic test_dmem_gaps();
    max_gap = 4;
    wd = {32'hDEADBEEF};
    make_frame(8'h02, 0);
    send_frame();
    checks++;
    if (obs.size() != 1 || obs[0] !== wr_t'({1'b1, 32'd0, 32'hDEADBEEF})) begin
      failures++;
      $display("FAIL dmem_gap got=%0d_writes first=%h exp=1_writes %h", obs.size(), obs.size() ? obs[0] : wr_t'(0), wr_t'({1'b1, 32'd0, 32'hDEADBEEF}));
    end
    checks++;
    if (done_cnt !== 1) begin failures++; $display("FAIL dmem_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_random_frames();
    max_gap = 3;
    for (int f = 0; f < 8; f++) begin
      wd = {};
      repeat ($urandom_range(6)) wd.push_back($urandom);
      make_frame($urandom_range(1) ? 8'h02 : 8'h01, 0);
      send_frame();
      checks++;
      if (obs.size() != exp_q.size()) begin failures++; $display("FAIL rand%0d_count got=%0d exp=%0d", f, obs.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < obs.size()) begin
        checks++;
        if (obs[i] !== exp_q[i]) begin failures++; $display("FAIL rand%0d_wr%0d got=%h exp=%h", f, i, obs[i], exp_q[i]); end
      end
      checks++;
      if (done_cnt !== int'(exp_done) || load_err !== exp_err) begin
        failures++;
        $display("FAIL rand%0d_flags got=done%0d/err%b exp=done%0d/err%b", f, done_cnt, load_err, exp_done, exp_err);
      end
    end
  endtask

  task automatic test_zero_count();
    wd = {};
    make_frame(8'h01, 0);
    send_frame();
    checks++;
    if (obs.size() != 0 || done_cnt !== 1) begin
      failures++;
      $display("FAIL zero_count got=%0d_writes/done%0d exp=0_writes/done1", obs.size(), done_cnt);
    end
  endtask

  task automatic test_overflow();
    max_gap = 0;
    wd = {};
    repeat (DEPTH + 1) wd.push_back($urandom);
    make_frame(8'h02, 0);
    send_frame();
    checks++;
    if (obs.size() != DEPTH) begin failures++; $display("FAIL ovf_count got=%0d exp=%0d", obs.size(), DEPTH); end
    foreach (exp_q[i]) if (i < obs.size()) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin failures++; $display("FAIL ovf_wr%0d got=%h exp=%h", i, obs[i], exp_q[i]); end
    end
    checks++;
    if (load_err !== 1'b1 || done_cnt !== 0) begin failures++; $display("FAIL ovf_flags got=err%b/done%0d exp=err1/done0", load_err, done_cnt); end
    wd = {$urandom};
    make_frame(8'h01, 0);
    send_frame();
    checks++;
    if (obs.size() != 1 || obs[0] !== exp_q[0]) begin failures++; $display("FAIL ovf_idle got=%0d_writes exp=1_writes %h", obs.size(), exp_q[0]); end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    max_gap = 2;
    wd = {$urandom, $urandom};
    make_frame(8'h01, 0);
    send_frame();
    checks++;
    if (obs.size() != 2 || done_cnt !== 1 || load_err !== 1'b0) begin
      failures++;
      $display("FAIL csum_good got=%0d_writes/done%0d/err%b exp=2_writes/done1/err0", obs.size(), done_cnt, load_err);
    end
    wd = {$urandom};
    make_frame(8'h02, 1);
    send_frame();
    checks++;
    if (obs.size() != 1 || obs[0] !== exp_q[0] || done_cnt !== 0 || load_err !== 1'b1) begin
      failures++;
      $display("FAIL csum_bad got=%0d_writes/done%0d/err%b exp=1_writes/done0/err1", obs.size(), done_cnt, load_err);
    end
    wd = {$urandom};
    make_frame(8'h01, 0);
    send_frame();
    checks++;
    if (obs.size() != 1 || obs[0] !== exp_q[0] || done_cnt !== 1) begin
      failures++;
      $display("FAIL csum_idle got=%0d_writes/done%0d exp=1_writes/done1", obs.size(), done_cnt);
    end
  endtask
`endif

  task automatic test_reset_midframe();
    do_reset();
    obs = {};
    wd = {32'h11223344};
    make_frame(8'h01, 0);
    for (int i = 0; i < 5; i++) send_byte(fb[i]);
    @(negedge clk);
    rx_valid = 0;
    #2 reset = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
    #1 checks++;
    if (obs.size() != 0 || rx_ready !== 1'b1 || load_err !== 1'b0 || core_reset !== 1'b1) begin
      failures++;
      $display("FAIL midreset got=%0d_writes/rdy%b/err%b/cr%b exp=0_writes/rdy1/err0/cr1", obs.size(), rx_ready, load_err, core_reset);
    end
    wd = {$urandom};
    make_frame(8'h02, 0);
    send_frame();
    checks++;
    if (obs.size() != 1 || obs[0] !== exp_q[0]) begin
      failures++;
      $display("FAIL midreset_realign got=%0d_writes first=%h exp=1_writes %h", obs.size(), obs.size() ? obs[0] : wr_t'(0), exp_q[0]);
    end
  endtask

  task automatic test_run();
    checks++;
    if (core_reset !== 1'b1) begin failures++; $display("FAIL run_pre got=%b exp=1", core_reset); end
    send_byte(8'h03);
    @(negedge clk);
    #1 checks++;
    if ({core_reset, load_done, rx_ready} !== 3'b010) begin failures++; $display("FAIL run_enter got=%b exp=010", {core_reset, load_done, rx_ready}); end
    obs = {};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rx_valid = 1;
      rx_data = 8'($urandom_range(3));
      #1 checks++;
      if ({core_reset, load_done, rx_ready, imem_we, dmem_we} !== 5'b0) begin
        failures++;
        $display("FAIL run_hold%0d got=%b exp=00000", i, {core_reset, load_done, rx_ready, imem_we, dmem_we});
      end
    end
    rx_valid = 0;
  endtask

  task automatic test_bad_cmd();
    do_reset();
    send_byte(8'h7F);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rx_data = 8'h01;
      #1 checks++;
      if ({load_err, rx_ready, core_reset} !== 3'b101) begin failures++; $display("FAIL badcmd%0d got=%b exp=101", i, {load_err, rx_ready, core_reset}); end
    end
    rx_valid = 0;
    reset = 0;
    #1 checks++;
    if ({rx_ready, imem_we, dmem_we, mem_addr, mem_wdata, core_reset, load_done, load_err} !== {3'b000, 64'd0, 3'b100}) begin
      failures++;
      $display("FAIL badcmd_reset got=%b/%h/%h/%b exp=000/0/0/100", {rx_ready, imem_we, dmem_we}, mem_addr, mem_wdata, {core_reset, load_done, load_err});
    end
    repeat (2) @(negedge clk);
    reset = 1;
  endtask

  initial begin
    test_reset();
    test_imem_fixed();
    test_dmem_gaps();
    test_random_frames();
    test_zero_count();
    test_overflow();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_midframe();
    test_run();
    test_bad_cmd();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
